// File: rtl/mem_responder_pkg.sv
// Shared widths, depth, loader state type and address range helper for the
// mem_responder block.
package mem_pkg;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 15;
  localparam int DEPTH  = 4096;
  localparam int IDX_W  = $clog2(DEPTH);

  typedef enum logic {
    LOAD,
    RUN
  } mem_state_t;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < (ADDR_W+1)'(DEPTH));
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU-side read/write ports and loader stream of mem_responder, bundled with
// master (CPU/loader source) and slave (memory) views.
interface mem_responder_if;
  import mem_pkg::*;

  logic [ADDR_W-1:0] raddr0;
  logic [WORD_W-1:0] rdata0;
  logic [ADDR_W-1:0] raddr1;
  logic [WORD_W-1:0] rdata1;
  logic              wen;
  logic [ADDR_W-1:0] waddr;
  logic [WORD_W-1:0] wdata;
  logic              load_valid;
  logic [WORD_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              ready;

  modport master (
    output raddr0, raddr1, wen, waddr, wdata, load_valid, load_data, load_last,
    input  rdata0, rdata1, load_ready, ready
  );

  modport slave (
    input  raddr0, raddr1, wen, waddr, wdata, load_valid, load_data, load_last,
    output rdata0, rdata1, load_ready, ready
  );

endinterface

// File: rtl/mem_responder_loader.sv
// LOAD/RUN sequencer: accepts the post-reset word stream, writes it from
// address 0 upward and hands over to the CPU ports on load_last or a full array.
module mem_loader
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              loadValid_i,
  input  logic [WORD_W-1:0] loadData_i,
  input  logic              loadLast_i,
  output logic              loadReady_o,
  output logic              run_o,
  output logic              wrEn_o,
  output logic [IDX_W-1:0]  wrAddr_o,
  output logic [WORD_W-1:0] wrData_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  mem_state_t       state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             loadReady_q, loadReady_d;
  logic             accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      loadReady_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      loadReady_q <= loadReady_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    loadReady_d = loadReady_q;
    accept      = 1'b0;
    case (state_q)
      LOAD: begin
        loadReady_d = 1'b1;
        accept      = loadValid_i & loadReady_q;
        if (accept) begin
          // The counter parks on the top word so a full array never wraps to 0.
          if (cnt_q != LAST_IDX) cnt_d = cnt_q + 1'b1;
          if (loadLast_i || (cnt_q == LAST_IDX)) begin
            state_d     = RUN;
            loadReady_d = 1'b0;
          end
        end
      end
      RUN: begin
        loadReady_d = 1'b0;
      end
      default: begin
        state_d     = LOAD;
        loadReady_d = 1'b0;
      end
    endcase
  end

  assign loadReady_o = loadReady_q;
  assign run_o       = (state_q == RUN);
  assign wrEn_o      = accept;
  assign wrAddr_o    = cnt_q;
  assign wrData_o    = loadData_i;

endmodule

// File: rtl/mem_responder.sv
// Word memory with two registered read ports and one write port, filled by a
// loader stream after reset. Define MEM_BYPASS_EN for write-first read-during-write.
module mem_responder
  import mem_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);

  logic [WORD_W-1:0] mem [DEPTH];

  logic              run;
  logic              loadWe;
  logic [IDX_W-1:0]  loadAddr;
  logic [WORD_W-1:0] loadData;
  logic              cpuWe;
  logic              memWe;
  logic [IDX_W-1:0]  memAddr;
  logic [WORD_W-1:0] memData;
  logic [WORD_W-1:0] rdata0_q, rdata0_d;
  logic [WORD_W-1:0] rdata1_q, rdata1_d;

  mem_loader uLoader (
    .clk         (clk),
    .reset       (reset),
    .loadValid_i (bus.load_valid),
    .loadData_i  (bus.load_data),
    .loadLast_i  (bus.load_last),
    .loadReady_o (bus.load_ready),
    .run_o       (run),
    .wrEn_o      (loadWe),
    .wrAddr_o    (loadAddr),
    .wrData_o    (loadData)
  );

  assign cpuWe   = run & bus.wen & in_range(bus.waddr);
  assign memWe   = loadWe | cpuWe;
  assign memAddr = run ? bus.waddr[IDX_W-1:0] : loadAddr;
  assign memData = run ? bus.wdata : loadData;

  // The array has no reset so its contents survive a reset mid-load.
  always_ff @(posedge clk) begin
    if (memWe) mem[memAddr] <= memData;
  end

  always_comb begin
    rdata0_d = '0;
    rdata1_d = '0;
    if (run) begin
      if (in_range(bus.raddr0)) rdata0_d = mem[bus.raddr0[IDX_W-1:0]];
      if (in_range(bus.raddr1)) rdata1_d = mem[bus.raddr1[IDX_W-1:0]];
`ifdef MEM_BYPASS_EN
      if (cpuWe && (bus.raddr0 == bus.waddr)) rdata0_d = bus.wdata;
      if (cpuWe && (bus.raddr1 == bus.waddr)) rdata1_d = bus.wdata;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign bus.rdata0 = rdata0_q;
  assign bus.rdata1 = rdata1_q;
  assign bus.ready  = run;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Responder (target) side of the CPU memory interface.
- Serves two independent word-read ports, one for instruction fetch and one for data loads, each with a 1-cycle registered read latency.
- Serves one word-write port for stores.
- After reset, a loader FSM fills memory from a word stream before the CPU ports go live; `ready` indicates the CPU-side ports are active.

Parameters:
- WORD_W, 16, data word width in bits.
- ADDR_W, 15, word-address width (byte address bits [15:1]).
- DEPTH, 4096, number of implemented words; addresses >= DEPTH are out of range.

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- raddr0  in  ADDR_W  fetch-port word address.
- rdata0  out  WORD_W  fetch-port read data, registered.
- raddr1  in  ADDR_W  data-port word address.
- rdata1  out  WORD_W  data-port read data, registered.
- wen  in  1  write enable.
- waddr  in  ADDR_W  write word address.
- wdata  in  WORD_W  write data.
- load_valid  in  1  loader stream word valid.
- load_data  in  WORD_W  loader stream word.
- load_last  in  1  marks final loader word.
- load_ready  out  1  loader accepts a word this cycle.
- ready  out  1  CPU ports active (state RUN).

Behaviour:
- Reset (async assert, sync to clk on release):
  - rdata0 = 0, rdata1 = 0, ready = 0, load_ready = 0.
  - State -> LOAD, load address counter = 0.
  - Array contents are NOT cleared by reset.
- States:
  - LOAD: load_ready = 1. On `load_valid & load_ready`, mem[cnt] <= load_data and cnt <= cnt+1.
    - If load_last is set on an accepted word, next state is RUN.
    - If the accepted word sits at cnt == DEPTH-1 without load_last, it is written, cnt saturates, and next state is RUN.
    - load_ready is registered; it goes 0 in the cycle RUN is entered.
  - RUN: ready = 1, load_ready = 0, load stream ignored. RUN is left only by reset.
- Reads in RUN:
  - raddr0/raddr1 are sampled at posedge t; rdata0/rdata1 hold mem[addr] after posedge t.
  - rdata holds its value until the next sampling edge, i.e. a new read every cycle.
  - Out-of-range address returns 0.
  - Both ports may read the same address in the same cycle.
- Reads outside RUN: rdata0/rdata1 are forced to 0.
- Writes:
  - In RUN, on posedge with wen = 1 and waddr < DEPTH: mem[waddr] <= wdata.
  - Out-of-range writes are dropped silently.
  - wen outside RUN is ignored.
- Read-during-write to the same address on the same edge: governed by MEM_BYPASS_EN (see Optional Feature).
- Write then read on the following cycle always returns the new data.
- Reset mid-LOAD: counter returns to 0 and the load restarts; already-written words persist until overwritten.
- Reset in RUN: ready drops asynchronously and rdata is zeroed.

Optional Feature:
- Macro: MEM_BYPASS_EN.
- Defined: a read on either port to waddr, sampled on the same edge as an in-range write, returns wdata (write-first).
- Undefined: that read returns the pre-write contents (read-first).
- Loader writes are not bypassed in either mode, because reads return 0 during LOAD.

Decomposition:
- Package mem_pkg:
  - WORD_W and ADDR_W constants.
  - State enum mem_state_t {LOAD, RUN}.
  - Helper function in_range(addr) comparing against DEPTH.
- One sub-module, mem_loader:
  - Holds the LOAD/RUN FSM, counter saturation and load_ready generation.
  - Outputs a write strobe, address and data into the array write mux.
  - Outputs a run flag.
- The array, read registers and bypass logic stay in mem_responder.

Test Plan:
- Reset, stream 4 words 0x1111, 0x2222, 0x3333, 0x4444 with load_last on the 4th -> load_ready drops and ready = 1 on the next cycle; raddr0 = 2 returns 0x3333 one cycle later.
- In RUN, raddr0 = 1 and raddr1 = 1 on the same cycle -> both rdata = 0x2222 after one edge; raddr1 = 5000 (>= DEPTH) -> rdata1 = 0.
- wen = 1, waddr = 3, wdata = 0xBEEF with raddr1 = 3 on the same edge -> rdata1 = 0xBEEF if MEM_BYPASS_EN, else 0x4444; next cycle rdata1 = 0xBEEF in both builds.
- Stream DEPTH words with load_last never asserted -> RUN entered after word DEPTH-1; mem[DEPTH-1] holds the last word and nothing wraps to address 0.
- Assert reset after 2 loader words, then reload 1 word 0xAAAA with load_last -> mem[0] = 0xAAAA and mem[1] retains its earlier value.
- Before RUN, drive wen = 1, waddr = 0, wdata = 0x5555 -> ignored; mem[0] is unchanged once RUN is reached.
